// File: rtl/cnn_layer_accel_sched_pkg.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_sched_pkg
// Shared types and defaults for the octo input scheduler.
//   sched_state_t : scheduler FSM states
//   C_DEF_*       : default bus / config widths
//   seq_zext()    : zero-extends a sequence word onto the pixel-wide datain bus
// ---------------------------------------------------------------------------
package cnn_layer_accel_sched_pkg;

    localparam int C_DEF_PIXEL_WIDTH    = 16;
    localparam int C_DEF_SEQ_DATA_WIDTH = 13;
    localparam int C_DEF_DIM_WIDTH      = 10;
    localparam int C_DEF_SEQ_CNT_WIDTH  = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NEWMAP = 3'd1,
        ST_SEQ    = 3'd2,
        ST_GAP    = 3'd3,
        ST_PIX    = 3'd4,
        ST_DONE   = 3'd5
    } sched_state_t;

    // Sequence words (RM, RST, P, 10-bit seq) ride in the low bits of datain.
    function automatic logic [C_DEF_PIXEL_WIDTH-1:0] seq_zext(
        input logic [C_DEF_SEQ_DATA_WIDTH-1:0] i_word
    );
        return {{(C_DEF_PIXEL_WIDTH-C_DEF_SEQ_DATA_WIDTH){1'b0}}, i_word};
    endfunction

endpackage

// File: rtl/cnn_layer_accel_stream_stage.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_stream_stage
// One-entry valid/ready output register that forwards at most i_limit words
// per phase.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_enable            : phase active; when low, counters and valid clear
//   i_limit             : number of words to forward in this phase
//   i_data/i_valid/o_rdy: upstream side
//   o_data/o_valid/i_out_rdy : downstream side
//   o_last              : the transfer in this cycle is the final one
//
// Handshake: a word moves when valid & rdy are both high at a rising edge.
// Once o_valid is high, o_data and o_valid hold until i_out_rdy is seen.
// o_rdy never depends on i_valid.
// ---------------------------------------------------------------------------
module cnn_layer_accel_stream_stage #(
    parameter int C_DATA_WIDTH = 16,
    parameter int C_CNT_WIDTH  = 20
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic [C_CNT_WIDTH-1:0]  i_limit,
    input  logic [C_DATA_WIDTH-1:0] i_data,
    input  logic                    i_valid,
    output logic                    o_rdy,
    output logic [C_DATA_WIDTH-1:0] o_data,
    output logic                    o_valid,
    input  logic                    i_out_rdy,
    output logic                    o_last
);

    logic [C_DATA_WIDTH-1:0] r_data;
    logic                    r_valid;
    logic [C_CNT_WIDTH-1:0]  r_accepted;  // words taken from upstream (issued + held)
    logic [C_CNT_WIDTH-1:0]  r_sent;      // words handed downstream
    logic                    w_xfer;
    logic                    w_accept;

    assign w_xfer   = r_valid & i_out_rdy;
    // Refill in the same cycle the held word leaves, but never past the limit.
    assign o_rdy    = i_enable & (~r_valid | w_xfer) & (r_accepted < i_limit);
    assign w_accept = o_rdy & i_valid;
    assign o_last   = w_xfer & (r_sent == (i_limit - C_CNT_WIDTH'(1)));
    assign o_data   = r_data;
    assign o_valid  = r_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_accepted <= '0;
            r_sent     <= '0;
        end else if (!i_enable) begin
            r_valid    <= 1'b0;
            r_accepted <= '0;
            r_sent     <= '0;
        end else begin
            if (w_accept) begin
                r_data     <= i_data;
                r_valid    <= 1'b1;
                r_accepted <= r_accepted + C_CNT_WIDTH'(1);
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            if (w_xfer) begin
                r_sent <= r_sent + C_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/cnn_layer_accel_octo_input_sched.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_octo_input_sched
// Sequences one feature-map load into cnn_layer_accel_octo: new_map pulse,
// seq_count sequence words, one idle gap cycle, rows*cols pixels, done pulse.
// Both sources share the octo's single datain bus through one output stage.
//   i_clk, i_rst                        : clock, synchronous active-high reset
//   i_start, i_num_*_cfg, i_seq_count_cfg : load request and its config
//   o_busy, o_done                      : load status
//   i_seq_in*, o_seq_in_rdy             : sequence-word source
//   i_pix_in*, o_pix_in_rdy             : pixel source
//   o_new_map, o_seq/pixel_datain_tag, i_seq/pixel_datain_rdy,
//   o_datain, o_datain_valid            : octo side
//   o_dbg_state                         : current FSM state
// ---------------------------------------------------------------------------
module cnn_layer_accel_octo_input_sched
    import cnn_layer_accel_sched_pkg::*;
#(
    parameter int C_PIXEL_WIDTH    = C_DEF_PIXEL_WIDTH,
    parameter int C_SEQ_DATA_WIDTH = C_DEF_SEQ_DATA_WIDTH,
    parameter int C_DIM_WIDTH      = C_DEF_DIM_WIDTH,
    parameter int C_SEQ_CNT_WIDTH  = C_DEF_SEQ_CNT_WIDTH
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [C_DIM_WIDTH-1:0]      i_num_rows_cfg,
    input  logic [C_DIM_WIDTH-1:0]      i_num_cols_cfg,
    input  logic [C_SEQ_CNT_WIDTH-1:0]  i_seq_count_cfg,
    output logic                        o_busy,
    output logic                        o_done,
    input  logic [C_SEQ_DATA_WIDTH-1:0] i_seq_in,
    input  logic                        i_seq_in_valid,
    output logic                        o_seq_in_rdy,
    input  logic [C_PIXEL_WIDTH-1:0]    i_pix_in,
    input  logic                        i_pix_in_valid,
    output logic                        o_pix_in_rdy,
    output logic                        o_new_map,
    output logic                        o_seq_datain_tag,
    input  logic                        i_seq_datain_rdy,
    output logic                        o_pixel_datain_tag,
    input  logic                        i_pixel_datain_rdy,
    output logic [C_PIXEL_WIDTH-1:0]    o_datain,
    output logic                        o_datain_valid,
    output logic [2:0]                  o_dbg_state
);

    localparam int C_TOT_WIDTH = 2 * C_DIM_WIDTH;

    sched_state_t               r_state;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_new_map;
    logic                       r_seq_tag;
    logic                       r_pix_tag;
    logic [C_SEQ_CNT_WIDTH-1:0] r_seq_count;
    logic [C_TOT_WIDTH-1:0]     r_pix_total;

    logic                       w_enable;
    logic [C_TOT_WIDTH-1:0]     w_limit;
    logic [C_PIXEL_WIDTH-1:0]   w_stage_data;
    logic                       w_stage_valid;
    logic                       w_stage_rdy;
    logic                       w_out_rdy;
    logic                       w_last;

    assign w_enable = (r_state == ST_SEQ) || (r_state == ST_PIX);

    // The single output stage is shared; the FSM state picks which source
    // and which octo ready it sees.
    always_comb begin
        w_stage_data  = '0;
        w_stage_valid = 1'b0;
        w_out_rdy     = 1'b0;
        w_limit       = '0;
        case (r_state)
            ST_SEQ: begin
                w_stage_data  = seq_zext(i_seq_in);
                w_stage_valid = i_seq_in_valid;
                w_out_rdy     = i_seq_datain_rdy;
                w_limit       = C_TOT_WIDTH'(r_seq_count);
            end
            ST_PIX: begin
                w_stage_data  = i_pix_in;
                w_stage_valid = i_pix_in_valid;
                w_out_rdy     = i_pixel_datain_rdy;
                w_limit       = r_pix_total;
            end
            default: ;
        endcase
    end

    cnn_layer_accel_stream_stage #(
        .C_DATA_WIDTH (C_PIXEL_WIDTH),
        .C_CNT_WIDTH  (C_TOT_WIDTH)
    ) u_stage (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_enable  (w_enable),
        .i_limit   (w_limit),
        .i_data    (w_stage_data),
        .i_valid   (w_stage_valid),
        .o_rdy     (w_stage_rdy),
        .o_data    (o_datain),
        .o_valid   (o_datain_valid),
        .i_out_rdy (w_out_rdy),
        .o_last    (w_last)
    );

    assign o_seq_in_rdy       = (r_state == ST_SEQ) & w_stage_rdy;
    assign o_pix_in_rdy       = (r_state == ST_PIX) & w_stage_rdy;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_new_map          = r_new_map;
    assign o_seq_datain_tag   = r_seq_tag;
    assign o_pixel_datain_tag = r_pix_tag;
    assign o_dbg_state        = r_state;

    // Outputs are registered alongside the state so they change on the same
    // edge as the state they describe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_new_map   <= 1'b0;
            r_seq_tag   <= 1'b0;
            r_pix_tag   <= 1'b0;
            r_seq_count <= '0;
            r_pix_total <= '0;
        end else begin
            r_new_map <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_seq_count <= i_seq_count_cfg;
                        r_pix_total <= C_TOT_WIDTH'(i_num_rows_cfg) * C_TOT_WIDTH'(i_num_cols_cfg);
                        r_state     <= ST_NEWMAP;
                        r_new_map   <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                ST_NEWMAP: begin
                    if (r_seq_count != '0) begin
                        r_state   <= ST_SEQ;
                        r_seq_tag <= 1'b1;
                    end else begin
                        r_state <= ST_GAP;
                    end
                end
                ST_SEQ: begin
                    if (w_last) begin
                        r_state   <= ST_GAP;
                        r_seq_tag <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (r_pix_total != '0) begin
                        r_state   <= ST_PIX;
                        r_pix_tag <= 1'b1;
                    end else begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_PIX: begin
                    if (w_last) begin
                        r_state   <= ST_DONE;
                        r_pix_tag <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_octo_input_sched.sv
// ---------------------------------------------------------------------------
// tb_cnn_layer_accel_octo_input_sched
// Self-checking bench: source words accepted by the scheduler are pushed to
// exp_q (tagged, zero-extended where needed) and popped on each datain
// transfer to the octo.
// ---------------------------------------------------------------------------
module tb_cnn_layer_accel_octo_input_sched;
    import cnn_layer_accel_sched_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  rows_cfg;
    logic [9:0]  cols_cfg;
    logic [11:0] seq_cnt_cfg;
    logic        busy;
    logic        done;
    logic [12:0] seq_in;
    logic        seq_in_valid;
    logic        seq_in_rdy;
    logic [15:0] pix_in;
    logic        pix_in_valid;
    logic        pix_in_rdy;
    logic        new_map;
    logic        seq_tag;
    logic        seq_datain_rdy;
    logic        pix_tag;
    logic        pixel_datain_rdy;
    logic [15:0] datain;
    logic        datain_valid;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    cnn_layer_accel_octo_input_sched dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_start            (start),
        .i_num_rows_cfg     (rows_cfg),
        .i_num_cols_cfg     (cols_cfg),
        .i_seq_count_cfg    (seq_cnt_cfg),
        .o_busy             (busy),
        .o_done             (done),
        .i_seq_in           (seq_in),
        .i_seq_in_valid     (seq_in_valid),
        .o_seq_in_rdy       (seq_in_rdy),
        .i_pix_in           (pix_in),
        .i_pix_in_valid     (pix_in_valid),
        .o_pix_in_rdy       (pix_in_rdy),
        .o_new_map          (new_map),
        .o_seq_datain_tag   (seq_tag),
        .i_seq_datain_rdy   (seq_datain_rdy),
        .o_pixel_datain_tag (pix_tag),
        .i_pixel_datain_rdy (pixel_datain_rdy),
        .o_datain           (datain),
        .o_datain_valid     (datain_valid),
        .o_dbg_state        (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [16:0] exp_q[$];       // {is_pixel, datain}
    logic [12:0] seq_src_q[$];
    logic [15:0] pix_src_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;

    logic [9:0]  nxt_rows;
    logic [9:0]  nxt_cols;
    logic [11:0] nxt_seq;
    bit          stall_mode;

    int  seq_xfer, pix_xfer, seq_acc, pix_acc;
    int  done_cnt, newmap_cnt, newmap_cyc, done_cyc;
    int  stab_err, excl_err, seq_tag_cyc;
    logic busy_at_newmap, busy_at_done;
    bit   prev_stall;
    logic [15:0] prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observes the handshakes that the next rising edge will complete.
    task automatic monitor();
        logic [16:0] e;
        logic        out_rdy;
        if (seq_in_valid && seq_in_rdy) begin
            exp_q.push_back({1'b0, 3'b000, seq_src_q[0]});
            void'(seq_src_q.pop_front());
            seq_acc++;
        end
        if (pix_in_valid && pix_in_rdy) begin
            exp_q.push_back({1'b1, pix_src_q[0]});
            void'(pix_src_q.pop_front());
            pix_acc++;
        end
        out_rdy = seq_tag ? seq_datain_rdy : (pix_tag ? pixel_datain_rdy : 1'b0);
        if (datain_valid && out_rdy) begin
            if (seq_tag) seq_xfer++;
            else pix_xfer++;
            if (exp_q.size() == 0) begin
                check("xfer_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("datain", {15'd0, pix_tag, datain}, {15'd0, e});
            end
        end
        if (prev_stall && (!datain_valid || datain != prev_data)) stab_err++;
        prev_stall = datain_valid && !out_rdy;
        prev_data  = datain;
        if ((seq_tag && pix_tag) || (datain_valid && !seq_tag && !pix_tag)) excl_err++;
        if (new_map) begin
            newmap_cnt++;
            newmap_cyc     = cyc;
            busy_at_newmap = busy;
        end
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
        if (seq_tag) seq_tag_cyc++;
        cyc++;
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit st, input bit rs);
        @(negedge clk);
        rst         = rs;
        start       = st;
        rows_cfg    = nxt_rows;
        cols_cfg    = nxt_cols;
        seq_cnt_cfg = nxt_seq;
        seq_in       = (seq_src_q.size() > 0) ? seq_src_q[0] : 13'd0;
        seq_in_valid = (seq_src_q.size() > 0) && (!stall_mode || $urandom_range(0, 3) != 0);
        pix_in       = (pix_src_q.size() > 0) ? pix_src_q[0] : 16'd0;
        pix_in_valid = (pix_src_q.size() > 0) && (!stall_mode || $urandom_range(0, 3) != 0);
        seq_datain_rdy   = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        pixel_datain_rdy = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        #1;
        monitor();
        if (rs) prev_stall = 1'b0;
    endtask

    task automatic run_load(input int rows, input int cols, input int seqn, input int extra,
                            input bit stall, input bit poke, input bit abort_mid);
        int tot;
        int start_cyc;
        int budget;
        int exp_lat;
        bit poked;
        bit finished;
        bit aborted;
        tot = rows * cols;
        poked = 0; finished = 0; aborted = 0;
        seq_xfer = 0; pix_xfer = 0; seq_acc = 0; pix_acc = 0;
        done_cnt = 0; newmap_cnt = 0; newmap_cyc = 0; done_cyc = 0;
        stab_err = 0; excl_err = 0; seq_tag_cyc = 0;
        busy_at_newmap = 1'b0; busy_at_done = 1'b1;
        exp_q.delete(); seq_src_q.delete(); pix_src_q.delete();
        for (int i = 0; i < seqn + extra; i++)
            seq_src_q.push_back((i == 0) ? 13'h1400 : 13'($urandom_range(0, 8191)));
        for (int i = 0; i < tot; i++)
            pix_src_q.push_back(16'($urandom_range(0, 65535)));
        stall_mode = stall;
        nxt_rows = rows[9:0];
        nxt_cols = cols[9:0];
        nxt_seq  = seqn[11:0];
        start_cyc = cyc;
        step(1'b1, 1'b0);
        budget = 4 * (seqn + tot) + 50;
        for (int k = 0; k < budget && !finished; k++) begin
            if (poke && !poked && pix_xfer >= 30) begin
                nxt_rows = 10'd2; nxt_cols = 10'd2; nxt_seq = 12'd5;
                step(1'b1, 1'b0);
                poked = 1;
            end else if (abort_mid && pix_xfer >= 42) begin
                step(1'b0, 1'b1);
                aborted = 1; finished = 1;
            end else begin
                step(1'b0, 1'b0);
            end
            if (done_cnt > 0) finished = 1;
        end
        if (aborted) begin
            step(1'b0, 1'b0);
            check("abort_outputs", {8'd0, busy, done, seq_in_rdy, pix_in_rdy, new_map, seq_tag,
                                    pix_tag, datain_valid, datain}, 32'd0);
            check("abort_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
            repeat (5) step(1'b0, 1'b0);
            check("abort_no_done", done_cnt, 0);
            return;
        end
        if (!finished) check("timeout", 32'd1, 32'd0);
        check("newmap_cnt", newmap_cnt, 1);
        check("newmap_lat", newmap_cyc - start_cyc, 1);
        check("busy_at_newmap", {31'd0, busy_at_newmap}, 32'd1);
        check("done_cnt", done_cnt, 1);
        check("busy_at_done", {31'd0, busy_at_done}, 32'd0);
        check("seq_acc", seq_acc, seqn);
        check("seq_xfer", seq_xfer, seqn);
        check("pix_xfer", pix_xfer, tot);
        check("exp_q_left", exp_q.size(), 0);
        check("seq_src_left", seq_src_q.size(), extra);
        check("stall_stable_err", stab_err, 0);
        check("tag_excl_err", excl_err, 0);
        if (!stall) begin
            exp_lat = 2 + ((seqn > 0) ? seqn + 1 : 0) + 1 + ((tot > 0) ? tot + 1 : 0);
            check("done_lat", done_cyc - start_cyc, exp_lat);
            check("seq_tag_cycles", seq_tag_cyc, (seqn > 0) ? seqn + 1 : 0);
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        rst = 1'b1; start = 1'b0;
        nxt_rows = '0; nxt_cols = '0; nxt_seq = '0; stall_mode = 0;
        seq_in = '0; seq_in_valid = 1'b0; pix_in = '0; pix_in_valid = 1'b0;
        seq_datain_rdy = 1'b1; pixel_datain_rdy = 1'b1;
        rows_cfg = '0; cols_cfg = '0; seq_cnt_cfg = '0;
        prev_stall = 0; prev_data = '0;
        repeat (3) step(1'b0, 1'b1);
        check("reset_outputs", {8'd0, busy, done, seq_in_rdy, pix_in_rdy, new_map, seq_tag,
                                pix_tag, datain_valid, datain}, 32'd0);
        check("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        step(1'b0, 1'b0);

        run_load(10, 10, 40, 0, 1'b0, 1'b0, 1'b0);  // full rate
        run_load(10, 10, 40, 0, 1'b1, 1'b0, 1'b0);  // random stalls
        run_load(3, 3, 0, 0, 1'b0, 1'b0, 1'b0);     // no sequence words
        run_load(0, 5, 0, 0, 1'b0, 1'b0, 1'b0);     // empty map
        run_load(10, 10, 40, 0, 1'b0, 1'b1, 1'b0);  // start + config change mid-load
        run_load(10, 10, 40, 0, 1'b0, 1'b0, 1'b0);  // start right after done
        run_load(10, 10, 40, 0, 1'b0, 1'b0, 1'b1);  // reset mid-pixel phase
        run_load(10, 10, 40, 0, 1'b0, 1'b0, 1'b0);  // fresh reload
        run_load(10, 10, 40, 5, 1'b0, 1'b0, 1'b0);  // surplus source words

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
